// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DM_BUSY,
        IF_BUSY
    } arb_state_t;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, grouped as one bundle.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              stall_f;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [3:0]        dm_be;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;
    logic              stall_m;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              timeout_err;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, if_kill,
        output if_valid, if_rdata, stall_f,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_valid, dm_rdata, stall_m,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata,
        output timeout_err
    );

    // Pipeline and memory side
    modport master (
        output if_req, if_addr, if_kill,
        input  if_valid, if_rdata, stall_f,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_valid, dm_rdata, stall_m,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata,
        input  timeout_err
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Counts busy cycles without an ack and flags expiry on the TIMEOUT-th one.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ack,
    output logic expire
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] countQ;

    // TIMEOUT of zero disables expiry; the counter then just wraps harmlessly.
    always_comb begin
        expire = (TIMEOUT != 0) && busy && !ack && (countQ == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countQ <= '0;
        end else if (!busy || ack || expire) begin
            countQ <= '0;
        end else begin
            countQ <= countQ + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and data access, one access in flight,
// data wins ties; supports fetch kill on redirect and a watchdog abort.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    arb_state_t        stateQ, stateD;
    logic              killedQ, killedD;
    logic              memReqQ;
    logic              memWeQ;
    logic [ADDR_W-1:0] memAddrQ;
    logic [DATA_W-1:0] memWdataQ;
    logic [3:0]        memBeQ;

    logic busy, ack, expire, done;
    logic grantDm, grantIf;
    logic ifValid, dmValid;

    assign busy    = (stateQ != IDLE);
    assign ack     = busy & bus.mem_ack;
    assign done    = ack | expire;
    assign grantDm = (stateQ == IDLE) & bus.dm_req;
    assign grantIf = (stateQ == IDLE) & ~bus.dm_req & bus.if_req & ~bus.if_kill;

    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .busy  (busy),
        .ack   (bus.mem_ack),
        .expire(expire)
    );

    always_comb begin
        stateD  = stateQ;
        killedD = killedQ;
        ifValid = 1'b0;
        dmValid = 1'b0;
        unique case (stateQ)
            IDLE: begin
                killedD = 1'b0;
                if (grantDm) begin
                    stateD = DM_BUSY;
                end else if (grantIf) begin
                    stateD = IF_BUSY;
                end
            end
            DM_BUSY: begin
                dmValid = ack;
                if (done) stateD = IDLE;
            end
            IF_BUSY: begin
                // A kill in the ack cycle itself still suppresses the instruction.
                ifValid = ack & ~killedQ & ~bus.if_kill;
                if (done) begin
                    stateD  = IDLE;
                    killedD = 1'b0;
                end else if (bus.if_kill) begin
                    killedD = 1'b1;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= IDLE;
            killedQ   <= 1'b0;
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            memBeQ    <= '0;
        end else begin
            stateQ  <= stateD;
            killedQ <= killedD;
            memReqQ <= (stateD != IDLE);
            if (grantDm) begin
                memWeQ    <= bus.dm_we;
                memAddrQ  <= bus.dm_addr;
                memWdataQ <= bus.dm_wdata;
                memBeQ    <= bus.dm_be;
            end else if (grantIf) begin
                memWeQ   <= 1'b0;
                memAddrQ <= bus.if_addr;
                memBeQ   <= BE_FULL;
            end
        end
    end

    assign bus.mem_req     = memReqQ;
    assign bus.mem_we      = memWeQ;
    assign bus.mem_addr    = memAddrQ;
    assign bus.mem_wdata   = memWdataQ;
    assign bus.mem_be      = memBeQ;

    assign bus.if_valid    = ifValid;
    assign bus.if_rdata    = ifValid ? bus.mem_rdata : '0;
    assign bus.dm_valid    = dmValid;
    assign bus.dm_rdata    = (dmValid & ~memWeQ) ? bus.mem_rdata : '0;
    assign bus.stall_f     = bus.if_req & ~ifValid;
    assign bus.stall_m     = bus.dm_req & ~dmValid;
    assign bus.timeout_err = expire;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int          fixLat   = -1;   // <0: random latency
    int          dataMode = 0;    // 0 random, 1 fixData, 2 address-derived
    logic [31:0] fixData  = 32'h0;
    bit          active   = 1'b0;
    int          rcnt, rlat;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req === 1'b1) begin
                if (!active) begin
                    active = 1'b1;
                    rcnt   = 0;
                    if (fixLat >= 0) rlat = fixLat;
                    else if ($urandom_range(15) == 0) rlat = 12;
                    else rlat = int'($urandom_range(3));
                end
                bus.mem_ack = (rcnt == rlat);
                if (bus.mem_ack && dataMode == 1) bus.mem_rdata = fixData;
                else if (bus.mem_ack && dataMode == 2) bus.mem_rdata = bus.mem_addr ^ 32'hC0DE_0000;
                else bus.mem_rdata = $urandom;
                rcnt++;
                if (bus.mem_ack) active = 1'b0;
            end else begin
                // Idle-time acks are noise the arbiter must ignore.
                active        = 1'b0;
                bus.mem_ack   = ($urandom_range(3) == 0);
                bus.mem_rdata = $urandom;
            end
        end
    end

    // ---------------- transaction model + per-cycle compare ----------------
    int          owner = 0;       // 0 none, 1 data, 2 fetch
    logic        curWe;
    logic [31:0] curAddr, curWdata;
    logic [3:0]  curBe;
    int          busyCnt;
    bit          curKilled;
    bit          ackNow, expNow, expIfV, expDmV;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                owner     = 0;
                busyCnt   = 0;
                curKilled = 1'b0;
                checkBit("rst_mem_req", bus.mem_req, 1'b0);
                checkBit("rst_timeout_err", bus.timeout_err, 1'b0);
            end else begin
                ackNow = (owner != 0) && bus.mem_ack;
                expNow = (owner != 0) && !bus.mem_ack && (busyCnt + 1 == int'(TO));
                expDmV = (owner == 1) && ackNow;
                expIfV = (owner == 2) && ackNow && !curKilled && !bus.if_kill;

                checkBit("mem_req", bus.mem_req, owner != 0);
                if (owner != 0) begin
                    check("mem_addr", bus.mem_addr, curAddr);
                    checkBit("mem_we", bus.mem_we, curWe);
                    check("mem_be", {28'h0, bus.mem_be}, {28'h0, curBe});
                    if (owner == 1) check("mem_wdata", bus.mem_wdata, curWdata);
                end
                checkBit("if_valid", bus.if_valid, expIfV);
                checkBit("dm_valid", bus.dm_valid, expDmV);
                checkBit("timeout_err", bus.timeout_err, expNow);
                check("if_rdata", bus.if_rdata, expIfV ? bus.mem_rdata : 32'h0);
                check("dm_rdata", bus.dm_rdata, (expDmV && !curWe) ? bus.mem_rdata : 32'h0);
                checkBit("stall_f", bus.stall_f, bus.if_req && !expIfV);
                checkBit("stall_m", bus.stall_m, bus.dm_req && !expDmV);

                if (owner != 0) begin
                    if (ackNow || expNow) begin
                        owner = 0;
                    end else begin
                        busyCnt++;
                        if (owner == 2 && bus.if_kill) curKilled = 1'b1;
                    end
                end else if (bus.dm_req) begin
                    owner = 1; curWe = bus.dm_we; curAddr = bus.dm_addr;
                    curWdata = bus.dm_wdata; curBe = bus.dm_be;
                    busyCnt = 0; curKilled = 1'b0;
                end else if (bus.if_req && !bus.if_kill) begin
                    owner = 2; curWe = 1'b0; curAddr = bus.if_addr; curBe = 4'hF;
                    busyCnt = 0; curKilled = 1'b0;
                end
            end
        end
    end

    // ---------------- random requesters ----------------
    bit randOn = 1'b0;
    bit dmDone, ifDone;

    initial begin
        forever begin
            @(negedge clk);
            dmDone = bus.dm_valid;
            ifDone = bus.if_valid;
            @(posedge clk);
            #1;
            if (randOn) begin
                if (dmDone) bus.dm_req = 1'b0;
                if (!bus.dm_req && $urandom_range(2) == 0) begin
                    bus.dm_req   = 1'b1;
                    bus.dm_we    = 1'($urandom_range(1));
                    bus.dm_addr  = 32'h2000 + ($urandom_range(255) << 2);
                    bus.dm_wdata = $urandom;
                    bus.dm_be    = 4'($urandom_range(15));
                end
                if (ifDone) bus.if_req = 1'b0;
                bus.if_kill = ($urandom_range(11) == 0);
                if (bus.if_kill) bus.if_addr = 32'h4000 + ($urandom_range(255) << 2);
                if (!bus.if_req && $urandom_range(1) == 0) begin
                    bus.if_req  = 1'b1;
                    bus.if_addr = 32'h1000 + ($urandom_range(255) << 2);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    function automatic logic cond(input int which);
        case (which)
            0:       return bus.if_valid;
            1:       return bus.dm_valid;
            2:       return bus.timeout_err;
            default: return bus.mem_req;
        endcase
    endfunction

    task automatic waitCond(input int which, input int maxCyc, input string name, output int n);
        n = -1;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            if (cond(which) === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: event absent within %0d cycles", name, maxCyc);
        end
    endtask

    task automatic nextDrive();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
        #1;
        checkBit("reset_mem_req", bus.mem_req, 1'b0);
        checkBit("reset_mem_we", bus.mem_we, 1'b0);
        check("reset_mem_addr", bus.mem_addr, 32'h0);
        check("reset_mem_wdata", bus.mem_wdata, 32'h0);
        check("reset_mem_be", {28'h0, bus.mem_be}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fetch only, memory acks two cycles after mem_req rises
        fixLat = 2; dataMode = 1; fixData = 32'h0050_0093;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        waitCond(0, 10, "t1_if_valid", n);
        check("t1_latency", n, 3);
        check("t1_if_rdata", bus.if_rdata, 32'h0050_0093);
        check("t1_mem_addr", bus.mem_addr, 32'h100);
        check("t1_mem_be", {28'h0, bus.mem_be}, 32'hF);
        checkBit("t1_stall_f_released", bus.stall_f, 1'b0);
        nextDrive(); bus.if_req = 1'b0;
        repeat (2) nextDrive();

        // Simultaneous requests: data first
        fixLat = 0; dataMode = 0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2000; bus.dm_be = 4'hF;
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        waitCond(1, 10, "t2_dm_valid", n);
        check("t2_dm_latency", n, 1);
        check("t2_dm_addr", bus.mem_addr, 32'h2000);
        checkBit("t2_if_not_yet", bus.if_valid, 1'b0);
        checkBit("t2_stall_f", bus.stall_f, 1'b1);
        nextDrive(); bus.dm_req = 1'b0;
        waitCond(0, 10, "t2_if_valid", n);
        check("t2_if_latency", n, 1);
        check("t2_if_addr", bus.mem_addr, 32'h104);
        nextDrive(); bus.if_req = 1'b0;
        repeat (2) nextDrive();

        // Store
        fixLat = 1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2004;
        bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_be = 4'b0011;
        waitCond(1, 10, "t3_dm_valid", n);
        check("t3_latency", n, 2);
        checkBit("t3_mem_we", bus.mem_we, 1'b1);
        check("t3_mem_addr", bus.mem_addr, 32'h2004);
        check("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("t3_mem_be", {28'h0, bus.mem_be}, 32'h3);
        check("t3_dm_rdata", bus.dm_rdata, 32'h0);
        nextDrive(); bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        repeat (2) nextDrive();

        // Kill the cycle after the fetch grant, then redirect
        fixLat = 2; dataMode = 2;
        bus.if_req = 1'b1; bus.if_addr = 32'h108;
        nextDrive(); bus.if_kill = 1'b1;
        nextDrive(); bus.if_kill = 1'b0; bus.if_addr = 32'h200;
        waitCond(0, 12, "t4_if_valid", n);
        check("t4_latency", n, 5);
        check("t4_mem_addr", bus.mem_addr, 32'h200);
        check("t4_if_rdata", bus.if_rdata, 32'hC0DE_0200);
        nextDrive(); bus.if_req = 1'b0;
        repeat (2) nextDrive();

        // Watchdog: memory never answers
        fixLat = 1000; dataMode = 0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h3000; bus.dm_be = 4'hF;
        waitCond(2, 20, "t5_timeout", n);
        check("t5_timeout_cycle", n, 8);
        checkBit("t5_no_valid", bus.dm_valid, 1'b0);
        fixLat = 0;
        @(negedge clk);
        checkBit("t5_mem_req_dropped", bus.mem_req, 1'b0);
        @(negedge clk);
        checkBit("t5_regrant", bus.mem_req, 1'b1);
        checkBit("t5_regrant_valid", bus.dm_valid, 1'b1);
        nextDrive(); bus.dm_req = 1'b0;
        repeat (2) nextDrive();

        // Async reset while data access is in flight
        fixLat = 5;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h4000;
        waitCond(3, 5, "t6_busy", n);
        check("t6_req_rise", n, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkBit("t6_mem_req_async", bus.mem_req, 1'b0);
        checkBit("t6_no_valid", bus.dm_valid, 1'b0);
        check("t6_mem_addr_cleared", bus.mem_addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        waitCond(1, 20, "t6_regrant", n);
        check("t6_regrant_addr", bus.mem_addr, 32'h4000);
        nextDrive(); bus.dm_req = 1'b0;
        repeat (2) nextDrive();

        // Random traffic
        fixLat = -1; dataMode = 0;
        @(negedge clk);
        randOn = 1'b1;
        repeat (3000) @(posedge clk);
        @(negedge clk);
        randOn = 1'b0;
        nextDrive();
        bus.dm_req = 1'b0; bus.if_req = 1'b0; bus.if_kill = 1'b0;
        repeat (20) nextDrive();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified single-ported memory between the fetch stage (instruction reads) and the memory stage (data loads and stores) of the 5-stage pipeline.
- Allows one transaction in flight. Data wins any tie.
- Produces per-requester stall signals that feed the hazard unit's enable logic.
- Handles fetch kills on branch/jump redirect and recovers from a memory that never acknowledges via a watchdog.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 (byte enables are 4 bits).
- TIMEOUT, 64, max cycles waiting for mem_ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch requests the word at if_addr
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  discard any fetch pending or in flight (PC redirect)
- if_valid  out  1  one-cycle pulse: if_rdata is valid
- if_rdata  out  DATA_W  instruction word
- stall_f  out  1  fetch must hold
- dm_req  in  1  data access request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  4  byte enables
- dm_valid  out  1  one-cycle pulse: access complete
- dm_rdata  out  DATA_W  load data
- stall_m  out  1  memory stage must hold
- mem_req  out  1  registered request to memory, held until mem_ack
- mem_we  out  1  registered write enable
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_be  out  4  registered byte enables (4'hF for fetch)
- mem_ack  in  1  completion; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  read data
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async): state IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_be, killed flag, watchdog count and timeout_err all 0.
- States: IDLE, DM_BUSY, IF_BUSY.
- IDLE, dm_req=1: latch the dm_* fields into the mem_* registers and go to DM_BUSY.
- IDLE, dm_req=0, if_req=1, if_kill=0: latch if_addr, set mem_we=0, mem_be=4'hF, go to IF_BUSY.
- IDLE, otherwise: stay in IDLE.
- mem_req=1 exactly while in a BUSY state. The request is registered, so mem_req rises the cycle after the grant decision.
- BUSY with mem_ack=1:
  - Drop mem_req and return to IDLE at the next edge.
  - Same cycle, combinationally: dm_valid=1 (DM_BUSY), or if_valid=1 (IF_BUSY and not killed).
  - rdata outputs equal mem_rdata when their valid is high, else 0. For stores dm_rdata=0.
- Minimum latency, request to valid, with a same-cycle-ack memory: 1 cycle (grant at edge t, ack and valid at t+1). The next grant occurs at the earliest in the IDLE cycle after the ack.
- Requesters hold req and all fields stable until their valid pulse; the arbiter does not check this.
- Stall outputs, combinational:
  - stall_f = if_req & ~if_valid
  - stall_m = dm_req & ~dm_valid
- Kill:
  - if_kill while in IF_BUSY sets the killed flag.
  - The memory access still completes, because stores and reads cannot be aborted.
  - On that ack, if_valid stays 0 and killed clears.
  - if_kill in IDLE blocks a fetch grant that cycle.
- Watchdog:
  - The counter increments each BUSY cycle without an ack and clears on entering IDLE.
  - When the count reaches TIMEOUT-1 with no ack: pulse timeout_err, drop mem_req, return to IDLE, no valid pulse. Requesters still asserting req are regranted normally.
- mem_ack in IDLE is ignored.
- Reset mid-transaction drops mem_req immediately; the memory model discards the access.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum (IDLE, DM_BUSY, IF_BUSY)
  - constant BE_FULL = 4'hF
- Sub-module mem_arb_watchdog holds the timeout counter. Its I/O: clk, rst, busy, ack, expire.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x100; memory acks 2 cycles after mem_req with 0x00500093 -> mem_addr=0x100, mem_be=F; if_valid one cycle with if_rdata=0x00500093; stall_f high until then.
2. Simultaneous: dm_req (load 0x2000) and if_req (0x104) in the same IDLE cycle -> data granted first, dm_valid precedes if_valid; stall_f stays high across both transactions.
3. Store: dm_we=1, dm_addr=0x2004, dm_wdata=0xDEADBEEF, dm_be=0011 -> mem_* fields match exactly; dm_valid pulses on ack; dm_rdata=0.
4. Kill: if_kill pulsed the cycle after the fetch grant of 0x108, then if_req at 0x200 -> no if_valid for 0x108; 0x200 granted after that ack; if_valid returns 0x200's data.
5. Timeout: TIMEOUT=8, memory never acks -> timeout_err pulses on the 8th BUSY cycle; mem_req drops; request is regranted the following IDLE cycle.
6. Async reset asserted while DM_BUSY -> mem_req=0 immediately, no dm_valid; after release, pending dm_req is regranted.
